// File: rtl/game_pkg.sv
// Shared types and constants for the game controllers.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SPAWN = 3'd2,
    DRAIN = 3'd3,
    CLEAR = 3'd4
  } sched_state_t;

  localparam int CLK_HZ_DEFAULT = 50_000_000;

  // Keyboard code that game-top decodes into a level start request.
  localparam logic [7:0] KEY_ENTER = 8'd40;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler. tick marks the last cycle of each second and is
// withheld while paused; clr restarts the second from zero.
module sec_tick
  import game_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic pause,
  output logic tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescale;

  // Prescaler counts 0..CLK_HZ-1 and freezes while paused; clr wins over pause.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prescale <= '0;
    end else if (clr) begin
      prescale <= '0;
    end else if (!pause) begin
      prescale <= (prescale == LAST) ? '0 : prescale + 1'b1;
    end
  end

  assign tick = (prescale == LAST) && !pause;

endmodule

// File: rtl/obstacle_scheduler.sv
// Level sequencer for the obstacle datapath: releases slots on a seconds
// schedule, restarts the level on collision, and clears once the last
// obstacle has left the screen.
//
// state | meaning
// IDLE  | waiting for start, no slots active
// LEAD  | lead-in time before slot 0 is released
// SPAWN | releasing one further slot every SPAWN_SECS
// DRAIN | all slots released, waiting for the last one to finish
// CLEAR | level cleared, shown for CLEAR_SECS before returning to IDLE
module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS  = 10,
  parameter int CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int LEAD_SECS  = 1,
  parameter int SPAWN_SECS = 2,
  parameter int CLEAR_SECS = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 collision,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] slot_en,
  output logic [9:0]           seconds,
  output logic                 tick,
  output logic                 restart,
  output logic                 level_clear,
  output logic                 busy,
  output logic [7:0]           hits
);

  localparam int RW = $clog2(NUM_SLOTS + 1);
  localparam logic [RW-1:0]        REL_ALL  = RW'(NUM_SLOTS);
  localparam logic [NUM_SLOTS-1:0] LAST_BIT = NUM_SLOTS'(1) << (NUM_SLOTS - 1);
  localparam logic [NUM_SLOTS-1:0] FIRST    = NUM_SLOTS'(1);

  sched_state_t  state;
  logic [7:0]    phase_sec;
  logic [RW-1:0] released;
  logic [RW-1:0] rel_next;
  logic          hit_accept;
  logic          last_done;
  logic          sec_clr;

  // Collisions only count while obstacles are in play.
  assign hit_accept = collision && (state == LEAD || state == SPAWN || state == DRAIN);
  // Only a released last slot may end the level.
  assign last_done  = |(slot_done & slot_en & LAST_BIT);
  // Holding the prescaler clear in IDLE makes every level start on a fresh second.
  assign sec_clr    = (state == IDLE) || hit_accept;
  assign rel_next   = released + 1'b1;

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (sec_clr),
    .pause (pause),
    .tick  (tick)
  );

  // Level FSM with its counters and the thermometer slot enable.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      phase_sec <= '0;
      released  <= '0;
      slot_en   <= '0;
      seconds   <= '0;
      restart   <= 1'b0;
      hits      <= '0;
    end else begin
      restart <= 1'b0;
      if (hit_accept) begin
        state     <= LEAD;
        phase_sec <= '0;
        released  <= '0;
        slot_en   <= '0;
        seconds   <= '0;
        restart   <= 1'b1;
        if (hits != 8'hFF) hits <= hits + 1'b1;
      end else begin
        if (state != IDLE && tick) begin
          seconds   <= seconds + 1'b1;
          phase_sec <= phase_sec + 1'b1;
        end
        case (state)
          IDLE: begin
            if (start) begin
              state     <= LEAD;
              phase_sec <= '0;
              released  <= '0;
              slot_en   <= '0;
              seconds   <= '0;
            end
          end
          LEAD: begin
            if (tick && phase_sec == 8'(LEAD_SECS - 1)) begin
              state     <= (NUM_SLOTS == 1) ? DRAIN : SPAWN;
              slot_en   <= FIRST;
              released  <= RW'(1);
              phase_sec <= '0;
            end
          end
          SPAWN: begin
            if (tick && phase_sec == 8'(SPAWN_SECS - 1)) begin
              slot_en   <= (slot_en << 1) | FIRST;
              released  <= rel_next;
              phase_sec <= '0;
              if (rel_next == REL_ALL) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (last_done) begin
              state     <= CLEAR;
              slot_en   <= '0;
              phase_sec <= '0;
            end
          end
          CLEAR: begin
            if (tick && phase_sec == 8'(CLEAR_SECS - 1)) begin
              state     <= IDLE;
              phase_sec <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy        = (state != IDLE);
  assign level_clear = (state == CLEAR);

endmodule
